// File: rtl/mult_accum_multi_if.sv
// ============================================================================
// mult_accum_multi_if : sample/result bus of the multi-channel saturating MAC
// Rev 1.0
// ============================================================================
`default_nettype none

interface mult_accum_multi_if #(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int ACC_W = 32,
  parameter int NCH   = 4,
  parameter int CH_W  = 2
) ();
  logic                    sclr;
  logic                    ce;
  logic                    load;
  logic [CH_W-1:0]         ch;
  logic signed [A_W-1:0]   a;
  logic signed [B_W-1:0]   b;
  logic                    out_valid;
  logic [CH_W-1:0]         out_ch;
  logic [ACC_W-1:0]        q;
  logic [NCH-1:0]          overflow;
  logic [NCH-1:0]          underflow;

  modport master (
    output sclr, ce, load, ch, a, b,
    input  out_valid, out_ch, q, overflow, underflow
  );

  modport slave (
    input  sclr, ce, load, ch, a, b,
    output out_valid, out_ch, q, overflow, underflow
  );
endinterface

`default_nettype wire

// File: rtl/mult_accum_multi.sv
// ============================================================================
// mult_accum_multi : NCH-channel time-shared signed MAC with saturation.
// Optional MULT_ACCUM_STICKY_FLAGS_EN makes overflow/underflow flags sticky.
// Rev 1.0
// ============================================================================
`default_nettype none

module mult_accum_multi #(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int ACC_W = 32,
  parameter int NCH   = 4,
  parameter int CH_W  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  mult_accum_multi_if.slave   bus
);

  localparam int P_W = A_W + B_W;
  localparam logic [CH_W:0] NCH_L = (CH_W+1)'(NCH);
  localparam logic signed [ACC_W:0]   SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   SUM_MIN = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // S1 stage
  logic                  s1_v_q, s1_v_d;
  logic                  s1_load_q, s1_load_d;
  logic [CH_W-1:0]       s1_ch_q, s1_ch_d;
  logic signed [A_W-1:0] s1_a_q, s1_a_d;
  logic signed [B_W-1:0] s1_b_q, s1_b_d;

  // S2 stage
  logic                  s2_v_q, s2_v_d;
  logic                  s2_load_q, s2_load_d;
  logic [CH_W-1:0]       s2_ch_q, s2_ch_d;
  logic signed [ACC_W:0] s2_prod_q, s2_prod_d;

  // S3 stage / outputs
  logic                  out_valid_q, out_valid_d;
  logic [CH_W-1:0]       out_ch_q, out_ch_d;
  logic [ACC_W-1:0]      q_q, q_d;
  logic [NCH-1:0]        ovf_q, ovf_d;
  logic [NCH-1:0]        unf_q, unf_d;

  logic signed [ACC_W-1:0] acc_q [NCH];
  logic signed [ACC_W-1:0] acc_d [NCH];

  logic signed [P_W-1:0]   w_a_ext;
  logic signed [P_W-1:0]   w_b_ext;
  logic signed [P_W-1:0]   w_mult;
  logic signed [ACC_W-1:0] w_acc_sel;
  logic signed [ACC_W:0]   w_sum;
  logic signed [ACC_W-1:0] w_acc_new;
  logic                    w_sat_hi;
  logic                    w_sat_lo;
  logic                    w_upd;

  // S1 and S2: capture sample, drop out-of-range tags, form the product
  always_comb begin
    s1_v_d    = bus.ce && ({1'b0, bus.ch} < NCH_L) && !bus.sclr;
    s1_load_d = bus.load;
    s1_ch_d   = bus.ch;
    s1_a_d    = bus.a;
    s1_b_d    = bus.b;

    w_a_ext   = {{B_W{s1_a_q[A_W-1]}}, s1_a_q};
    w_b_ext   = {{A_W{s1_b_q[B_W-1]}}, s1_b_q};
    w_mult    = w_a_ext * w_b_ext;

    s2_v_d    = s1_v_q && !bus.sclr;
    s2_load_d = s1_load_q;
    s2_ch_d   = s1_ch_q;
    s2_prod_d = {{(ACC_W+1-P_W){w_mult[P_W-1]}}, w_mult};
  end

  // S3: read-modify-write of the addressed accumulator
  always_comb begin
    w_acc_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (s2_ch_q == CH_W'(i)) w_acc_sel = acc_q[i];
    end

    w_sum     = s2_load_q ? s2_prod_q : ({w_acc_sel[ACC_W-1], w_acc_sel} + s2_prod_q);
    w_sat_hi  = (w_sum > SUM_MAX);
    w_sat_lo  = (w_sum < SUM_MIN);
    w_acc_new = w_sat_hi ? ACC_MAX : (w_sat_lo ? ACC_MIN : w_sum[ACC_W-1:0]);
    w_upd     = s2_v_q && !bus.sclr;

    out_valid_d = w_upd;
    out_ch_d    = w_upd ? s2_ch_q : out_ch_q;
    q_d         = w_upd ? w_acc_new : q_q;

`ifdef MULT_ACCUM_STICKY_FLAGS_EN
    ovf_d = ovf_q;
    unf_d = unf_q;
`else
    ovf_d = '0;
    unf_d = '0;
`endif

    for (int i = 0; i < NCH; i++) begin
      acc_d[i] = acc_q[i];
      if (w_upd && (s2_ch_q == CH_W'(i))) begin
        acc_d[i] = w_acc_new;
`ifdef MULT_ACCUM_STICKY_FLAGS_EN
        // A load restarts the channel, so its history of saturation is dropped
        if (s2_load_q) begin
          ovf_d[i] = 1'b0;
          unf_d[i] = 1'b0;
        end
`endif
        if (w_sat_hi) ovf_d[i] = 1'b1;
        if (w_sat_lo) unf_d[i] = 1'b1;
      end
      if (bus.sclr) acc_d[i] = '0;
    end

    if (bus.sclr) begin
      ovf_d = '0;
      unf_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s1_load_q   <= 1'b0;
      s1_ch_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s2_v_q      <= 1'b0;
      s2_load_q   <= 1'b0;
      s2_ch_q     <= '0;
      s2_prod_q   <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      q_q         <= '0;
      ovf_q       <= '0;
      unf_q       <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_load_q   <= s1_load_d;
      s1_ch_q     <= s1_ch_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s2_v_q      <= s2_v_d;
      s2_load_q   <= s2_load_d;
      s2_ch_q     <= s2_ch_d;
      s2_prod_q   <= s2_prod_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      q_q         <= q_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_acc
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q[gi] <= '0;
        else        acc_q[gi] <= acc_d[gi];
      end
    end
  endgenerate

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.q         = q_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_accum_multi.sv
// ============================================================================
// tb_mult_accum_multi : directed bench for mult_accum_multi (NCH=4, CH_W=3
// so that out-of-range tags are representable). Rev 1.0
// ============================================================================
`default_nettype none

module tb_mult_accum_multi;

  localparam int A_W   = 16;
  localparam int B_W   = 16;
  localparam int ACC_W = 32;
  localparam int NCH   = 4;
  localparam int CH_W  = 3;
`ifdef MULT_ACCUM_STICKY_FLAGS_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_accum_multi_if #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .NCH(NCH), .CH_W(CH_W)) bus ();

  mult_accum_multi #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .NCH(NCH), .CH_W(CH_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [CH_W-1:0]  ch;
    logic [ACC_W-1:0] q;
    logic [NCH-1:0]   ov;
    logic [NCH-1:0]   un;
  } exp_t;

  exp_t     eq[$];
  int       checks   = 0;
  int       failures = 0;
  logic [2:0] pv     = 3'b000;
  logic     cur_v    = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the out_valid timing model is a 3-deep shift of issued samples
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    pv = {pv[1:0], cur_v};
    chk("out_valid", {63'd0, bus.out_valid}, {63'd0, pv[2]});
    if (pv[2]) begin
      if (eq.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL scoreboard_empty observed=valid expected=none");
      end else begin
        e = eq.pop_front();
        chk("q",         {32'd0, bus.q},         {32'd0, e.q});
        chk("out_ch",    {61'd0, bus.out_ch},    {61'd0, e.ch});
        chk("overflow",  {60'd0, bus.overflow},  {60'd0, e.ov});
        chk("underflow", {60'd0, bus.underflow}, {60'd0, e.un});
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [CH_W-1:0] c, input logic [15:0] a, input logic [15:0] b,
                      input logic ld, input logic [31:0] exp_q,
                      input logic [3:0] ov, input logic [3:0] un);
    exp_t e;
    bus.ce   = 1'b1;
    bus.ch   = c;
    bus.a    = a;
    bus.b    = b;
    bus.load = ld;
    cur_v    = (c < CH_W'(NCH));
    if (cur_v) begin
      e.ch = c; e.q = exp_q; e.ov = ov; e.un = un;
      eq.push_back(e);
    end
    tick();
    bus.ce   = 1'b0;
    bus.load = 1'b0;
    cur_v    = 1'b0;
  endtask

  task automatic do_sclr();
    bus.sclr = 1'b1;
    bus.ce   = 1'b1;
    bus.ch   = '0;
    bus.a    = 16'h7FFF;
    bus.b    = 16'h7FFF;
    pv       = 3'b000;
    cur_v    = 1'b0;
    eq.delete();
    tick();
    bus.sclr = 1'b0;
    bus.ce   = 1'b0;
  endtask

  initial begin
    bus.sclr = 1'b0;
    bus.ce   = 1'b0;
    bus.load = 1'b0;
    bus.ch   = '0;
    bus.a    = '0;
    bus.b    = '0;

    // Reset state
    idle(2);
    chk("rst_q",         {32'd0, bus.q},         64'd0);
    chk("rst_out_ch",    {61'd0, bus.out_ch},    64'd0);
    chk("rst_overflow",  {60'd0, bus.overflow},  64'd0);
    chk("rst_underflow", {60'd0, bus.underflow}, 64'd0);
    rst_n = 1'b1;

    // Positive ramp into the rail, then step back off it
    for (int k = 1; k <= 15; k++)
      send(3'd0, 16'h4000, 16'h2000, 1'b0, 32'(k) * 32'h0800_0000, 4'b0000, 4'b0000);
    send(3'd0, 16'h4000, 16'h2000, 1'b0, 32'h7FFF_FFFF, 4'b0001, 4'b0000);
    idle(3);
    chk("ovf_after_sat", {60'd0, bus.overflow}, STICKY ? 64'd1 : 64'd0);
    send(3'd0, 16'h4000, 16'hE000, 1'b0, 32'h77FF_FFFF, STICKY ? 4'b0001 : 4'b0000, 4'b0000);
    idle(3);
    chk("ovf_hold", {60'd0, bus.overflow}, STICKY ? 64'd1 : 64'd0);
    send(3'd0, 16'h0001, 16'h0001, 1'b1, 32'h0000_0001, 4'b0000, 4'b0000);
    idle(3);
    chk("ovf_after_load", {60'd0, bus.overflow}, 64'd0);

    // Negative ramp: exactly min is not saturation, the next one is
    for (int k = 1; k <= 16; k++)
      send(3'd1, 16'h4000, 16'hE000, 1'b0, 32'h0 - (32'(k) << 27), 4'b0000, 4'b0000);
    send(3'd1, 16'h4000, 16'hE000, 1'b0, 32'h8000_0000, 4'b0000, 4'b0010);
    idle(3);
    chk("unf_idle", {60'd0, bus.underflow}, STICKY ? 64'd2 : 64'd0);

    // Round-robin, back to back, no cross-talk
    do_sclr();
    for (int r = 1; r <= 8; r++)
      for (int c = 0; c < 4; c++)
        send(3'(c), 16'd1, 16'(c + 1), 1'b0, 32'(r * (c + 1)), 4'b0000, 4'b0000);
    idle(3);

    // Load, then sclr with two samples in flight
    send(3'd2, 16'd50, 16'd1, 1'b1, 32'd50,  4'b0000, 4'b0000);
    send(3'd2, 16'd50, 16'd1, 1'b0, 32'd100, 4'b0000, 4'b0000);
    send(3'd2, 16'd3,  16'd5, 1'b1, 32'd15,  4'b0000, 4'b0000);
    send(3'd0, 16'd1,  16'd1, 1'b0, 32'd9,   4'b0000, 4'b0000);
    send(3'd1, 16'd1,  16'd1, 1'b0, 32'd17,  4'b0000, 4'b0000);
    do_sclr();
    idle(3);
    for (int c = 0; c < 4; c++)
      send(3'(c), 16'd0, 16'd0, 1'b0, 32'd0, 4'b0000, 4'b0000);
    idle(3);

    // Out-of-range tag is dropped
    send(3'd1, 16'd7,     16'd1,     1'b1, 32'd7, 4'b0000, 4'b0000);
    send(3'd5, 16'h4000,  16'h4000,  1'b1, 32'd0, 4'b0000, 4'b0000);
    send(3'd1, 16'd0,     16'd0,     1'b0, 32'd7, 4'b0000, 4'b0000);
    idle(3);
    chk("pre_rst_q", {32'd0, bus.q}, 64'd7);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q",         {32'd0, bus.q},         64'd0);
    chk("arst_out_ch",    {61'd0, bus.out_ch},    64'd0);
    chk("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    #2 rst_n = 1'b1;
    pv = 3'b000;
    eq.delete();
    send(3'd1, 16'd0, 16'd0, 1'b0, 32'd0, 4'b0000, 4'b0000);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
